// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer: data/opcode widths,
// the ALU opcodes it issues, and the controller state type.
package alu_mul_sequencer_pkg;

  localparam int BYTE_W = 8;
  localparam int OP_W   = 4;

  // ALU opcodes driven on pgmOp while the sequencer owns the ALU
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_LSL = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned multiply controller that borrows the shared single-cycle
// ALU. Each multiplier bit costs one ADD cycle (add mcand or 0 into acc) and one
// LSL cycle (mcand <<= 1). Result is the low W bits of the product plus a
// sticky overflow flag.
//
// Handshake: start is a request that is accepted only on a clock edge where the
// controller is in IDLE; requests in any other state are dropped, not queued.
// done pulses for exactly one cycle, and result/ovf are valid from that cycle
// until the next accepted start.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int W   = BYTE_W,
  parameter int OPW = OP_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic           ovf,
  output logic           alu_own,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  output seq_state_t     dbg_state
);

  seq_state_t   state;
  logic [W-1:0] acc;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic         ovf_int;
  logic [W-1:0] result_q;
  logic         ovf_q;
  logic [W-1:0] mplier_shr;

  // multiplier after consuming its current LSB; zero means no more partial products
  assign mplier_shr = mplier >> 1;
  assign dbg_state  = state;

  // controller state, datapath registers and held result
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      ovf_int  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            mcand   <= op_a;
            mplier  <= op_b;
            ovf_int <= 1'b0;
            state   <= (op_b != '0) ? ADD : DONE;
          end
        end
        ADD: begin
          acc <= alu_out;
          // a wrapped sum is smaller than the addend already in acc
          if (alu_out < acc) ovf_int <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          mcand  <= alu_out;
          mplier <= mplier_shr;
          // the bit shifted out of mcand would still have been added later
          if (mcand[W-1] && (mplier_shr != '0)) ovf_int <= 1'b1;
          state <= (mplier_shr == '0) ? DONE : ADD;
        end
        DONE: begin
          result_q <= acc;
          ovf_q    <= ovf_int;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output decode; result/ovf bypass the hold registers in DONE so they line up with done
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    alu_own = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    result  = result_q;
    ovf     = ovf_q;
    case (state)
      ADD: begin
        busy    = 1'b1;
        alu_own = 1'b1;
        alu_op  = OPW'(OP_ADD);
        alu_a   = acc;
        alu_b   = mplier[0] ? mcand : '0;
      end
      SHIFT: begin
        busy    = 1'b1;
        alu_own = 1'b1;
        alu_op  = OPW'(OP_LSL);
        alu_a   = mcand;
        alu_b   = {{(W-1){1'b0}}, 1'b1};
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        result = acc;
        ovf    = ovf_int;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural ALU on the alu_* ports, a
// transaction-level model of the multiply (product, overflow, latency), a
// per-cycle compare process and directed plus random multiplies.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  localparam int W   = BYTE_W;
  localparam int OPW = OP_W;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           ovf;
  logic           alu_own;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_out;
  seq_state_t     dbg_state;

  int checks   = 0;
  int failures = 0;
  bit checking = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_mul_sequencer #(.W(W), .OPW(OPW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf),
    .alu_own   (alu_own),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .dbg_state (dbg_state)
  );

  // behavioural shared ALU
  assign alu_out = (alu_op == OP_ADD) ? W'(alu_a + alu_b) :
                   (alu_op == OP_LSL) ? W'(alu_a << alu_b) : '0;

  // ---------------- model ----------------
  function automatic int lat_of(input logic [W-1:0] b);
    int m;
    m = -1;
    for (int i = 0; i < W; i++) if (b[i]) m = i;
    return (m < 0) ? 1 : 2 * (m + 1) + 1;
  endfunction

  function automatic logic [W:0] prod_of(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return {(p > 255), W'(p % 256)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [W:0] exp_q[$];   // {ovf, result} per accepted multiply
  bit         m_active;
  int         m_cyc;
  int         m_lat;
  logic [W:0] m_pend;
  logic [W:0] m_held;

  // transaction model: accept, cycle count since accept, commit on done
  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_cyc    <= 0;
      m_held   <= '0;
      exp_q.delete();
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_cyc    <= 1;
        m_lat    <= lat_of(op_b);
        m_pend   <= prod_of(op_a, op_b);
        exp_q.push_back(prod_of(op_a, op_b));
      end
    end else if (m_cyc == m_lat) begin
      m_active <= 1'b0;
      m_held   <= m_pend;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (checking && !reset) begin
      logic       e_done, e_own;
      logic [W:0] e_out, got;
      e_done = m_active && (m_cyc == m_lat);
      e_own  = m_active && (m_cyc < m_lat);
      e_out  = e_done ? m_pend : m_held;
      check("busy", busy, m_active);
      check("done", done, e_done);
      check("alu_own", alu_own, e_own);
      check("result", result, e_out[W-1:0]);
      check("ovf", ovf, e_out[W]);
      if (e_own) begin
        check("alu_op", alu_op, (m_cyc % 2 == 1) ? OP_ADD : OP_LSL);
        if (m_cyc % 2 == 0) check("alu_b_lsl", alu_b, 1);
      end else begin
        check("alu_idle_drive", {alu_a, alu_b, alu_op}, 0);
      end
      if (done) begin
        if (exp_q.size() == 0) check("sb_unexpected_done", 1, 0);
        else begin
          got = {ovf, result};
          check("sb_result", got, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_res, input int exp_ovf, input int exp_lat,
                         input int exp_own);
    int cnt, own_cnt;
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    cnt = 1; own_cnt = 0;
    while (!done && cnt < 40) begin
      if (alu_own) own_cnt++;
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, exp_lat);
    check("done_result", result, exp_res);
    check("done_ovf", ovf, exp_ovf);
    check("own_cycles", own_cnt, exp_own);
    @(negedge clk);
    check("held_result", result, exp_res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    bit saw_done;
    logic [W-1:0] ra, rb;
    logic [W:0]   rp;
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_own", alu_own, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    checking = 1;
    reset = 1'b0;

    // 5*3: four ALU cycles, done in cycle 5
    run_mul(8'd5, 8'd3, 15, 0, 5, 4);
    // 9*0: straight to DONE
    run_mul(8'd9, 8'd0, 0, 0, 1, 0);
    // 16*16: bit lost at 4th shift
    run_mul(8'd16, 8'd16, 0, 1, 11, 10);
    run_mul(8'd255, 8'd255, 1, 1, 17, 16);

    // 7*6 with a second start in cycle 2 that must be ignored
    start = 1'b1; op_a = 8'd7; op_b = 8'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op_a = 8'd1; op_b = 8'd1;
    @(negedge clk); start = 1'b0;
    cnt = 3;
    while (!done && cnt < 40) begin @(negedge clk); cnt++; end
    check("ignored_start_latency", cnt, 7);
    check("ignored_start_result", result, 42);
    @(negedge clk);
    // back-to-back start in the cycle after done
    run_mul(8'd1, 8'd1, 1, 0, 3, 2);

    // 200*128 aborted by reset in cycle 6
    start = 1'b1; op_a = 8'd200; op_b = 8'd128;
    @(negedge clk); start = 1'b0;
    saw_done = 0;
    repeat (5) begin @(negedge clk); if (done) saw_done = 1; end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_own", alu_own, 0);
    check("abort_alu", {alu_a, alu_b, alu_op}, 0);
    check("abort_result", result, 0);
    check("abort_ovf", ovf, 0);
    reset = 1'b0;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    check("abort_no_done", saw_done, 0);

    // random pairs
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rp = prod_of(ra, rb);
      run_mul(ra, rb, rp[W-1:0], rp[W], lat_of(rb), lat_of(rb) - 1);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
